// File: rtl/ifetch_pkg.sv
// Shared fetch-controller constants: FSM state encoding and default bus widths.
// Pure declarations; no logic, latency or backpressure of its own.
package ifetch_pkg;
  localparam int ST_W       = 2;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [ST_W-1:0] S_IDLE = 2'd0;
  localparam logic [ST_W-1:0] S_REQ  = 2'd1;
  localparam logic [ST_W-1:0] S_HOLD = 2'd2;
  localparam logic [ST_W-1:0] S_DROP = 2'd3;
endpackage

// File: rtl/ifetch_timer.sv
// Ack-timeout counter: o_expired is combinational and fires in the TO_CYCLES-th wait cycle.
// No backpressure; i_clr wins over i_inc.
module ifetch_timer #(
  parameter int TO_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TO_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expire on the edge at which the count would reach TO_CYCLES.
  assign o_expired = i_inc && !i_clr && (r_cnt == CNT_W'(TO_CYCLES - 1));
endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch handshake controller: issues one registered imem request per PC and holds the result for ID.
// Min 3 cycles/instr; stall_d holds the instruction; flush_d redirects. Timeout under IFETCH_TIMEOUT_EN.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TO_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  pc,
  output logic              pc_en,
  input  logic              stall_d,
  input  logic              flush_d,
  output logic              imem_req,
  output logic [WIDTH-1:0]  imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr_f,
  output logic              instr_valid_f,
  output logic              fetch_err
);
  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_next;
  logic              r_req;
  logic [WIDTH-1:0]  r_addr;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              w_expired;
  logic              w_pc_en;
  logic              w_busy;
  logic              w_busy_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (!flush_d) w_next = S_REQ;
      S_REQ: begin
        if (imem_ack)       w_next = flush_d ? S_IDLE : S_HOLD;
        else if (w_expired) w_next = S_IDLE;
        else if (flush_d)   w_next = S_DROP;
      end
      S_HOLD: if (flush_d || !stall_d) w_next = S_IDLE;
      S_DROP: if (imem_ack || w_expired) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pc_en = 1'b0;
    if (rst) begin
      case (r_state)
        S_HOLD:  w_pc_en = flush_d || !stall_d;
        default: w_pc_en = flush_d;
      endcase
    end
  end

  assign w_busy      = (r_state == S_REQ) || (r_state == S_DROP);
  assign w_busy_next = (w_next == S_REQ) || (w_next == S_DROP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_next == S_REQ) begin
        r_req  <= 1'b1;
        r_addr <= pc;
      end else if (w_busy && !w_busy_next) begin
        r_req <= 1'b0;
      end
      if (r_state == S_REQ && w_next == S_HOLD) begin
        r_instr <= imem_rdata;
        r_valid <= 1'b1;
      end else if (r_state == S_HOLD && w_next == S_IDLE) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  logic w_clr;
  logic w_inc;
  logic r_err;

  // Restart the count on every entry to REQ (from IDLE) and on the REQ->DROP hand-over.
  assign w_clr = !w_busy || (r_state == S_REQ && flush_d && !imem_ack);
  assign w_inc = w_busy && !imem_ack;

  ifetch_timer #(.TO_CYCLES(TO_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_inc     (w_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_expired) begin
      r_err <= 1'b1;
    end
  end

  assign fetch_err = r_err;
`else
  assign w_expired = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign pc_en         = w_pc_en;
  assign imem_req      = r_req;
  assign imem_addr     = r_addr;
  assign instr_f       = r_instr;
  assign instr_valid_f = r_valid;
endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch handshake controller on the consumer side of the PC register.
- Takes the current PC, issues a req/ack read to instruction memory, and presents the returned instruction to the ID stage.
- Drives `pc_en` back to the PC register, so the PC advances only when an instruction has been consumed or a redirect occurs.
- Handles multi-cycle memory latency, decode stalls and branch flushes.

Parameters:
- WIDTH, 32, PC / instruction address width
- DATA_W, 32, instruction word width
- TO_CYCLES, 16, ack timeout in cycles (used only with IFETCH_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- pc  in  WIDTH  current PC register value
- pc_en  out  1  load enable for the PC register (combinational)
- stall_d  in  1  ID stage cannot accept an instruction this cycle
- flush_d  in  1  redirect; PC loads branch/jump target on the next edge
- imem_req  out  1  fetch request, registered
- imem_addr  out  WIDTH  fetch address, registered, stable while imem_req=1
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  DATA_W  instruction data, valid with imem_ack
- instr_f  out  DATA_W  fetched instruction, registered
- instr_valid_f  out  1  instr_f holds an unconsumed instruction
- fetch_err  out  1  sticky timeout flag (0 without IFETCH_TIMEOUT_EN)

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; imem_req=0, imem_addr=0, instr_f=0, instr_valid_f=0, fetch_err=0. pc_en=0 while in reset.
- Reset mid-request abandons the transaction; a late ack is ignored because state is IDLE.
- IDLE:
  - next edge: imem_addr<=pc, imem_req<=1, go REQ.
  - flush_d in IDLE: pc_en=1, stay IDLE, so the new pc is sampled one cycle later.
- REQ: imem_req and imem_addr held constant.
  - ack & !flush_d: instr_f<=imem_rdata, instr_valid_f<=1, imem_req<=0, go HOLD; pc_en=0.
  - ack & flush_d: data discarded, imem_req<=0, pc_en=1, go IDLE.
  - !ack & flush_d: pc_en=1, go DROP; the request stays asserted with its old address.
  - otherwise: stay REQ.
- HOLD: instr_valid_f=1, instr_f stable.
  - flush_d (priority over stall_d): pc_en=1, instr_valid_f<=0, go IDLE.
  - !stall_d: pc_en=1, instr_valid_f<=0, go IDLE. The ID register captures instr_f on this same edge.
  - stall_d: pc_en=0, stay HOLD.
- DROP: waiting out a stale request.
  - ack: discard data, imem_req<=0, go IDLE.
  - flush_d: pc_en=1 (newest target wins), stay DROP or exit per ack.
- pc_en is asserted only in the cases listed above. It is never asserted in REQ without ack or flush.
- Minimum throughput: 3 cycles per instruction with same-cycle ack (IDLE, REQ, HOLD).
- imem_req never deasserts before imem_ack, except on reset or timeout.
- State encoding: IDLE=2'd0, REQ=2'd1, HOLD=2'd2, DROP=2'd3.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- With the macro: an $clog2(TO_CYCLES+1)-bit counter clears on entry to REQ/DROP and increments each cycle without ack. When it reaches TO_CYCLES:
  - imem_req<=0, fetch_err<=1 (sticky until reset), go IDLE;
  - instr_valid_f stays 0.
- Without the macro: no counter; fetch_err tied 0; REQ/DROP wait indefinitely.

Decomposition:
- Shared package ifetch_pkg:
  - state encoding localparams (S_IDLE, S_REQ, S_HOLD, S_DROP);
  - state width constant;
  - default WIDTH/DATA_W.
- One sub-module: ifetch_timer, the timeout counter with clr/inc/expired, instantiated only under IFETCH_TIMEOUT_EN.

Test Plan:
- Reset: rst=0 for 2 cycles → all outputs 0. After release: 1 cycle IDLE, then imem_req=1 and imem_addr=pc (0x0000_0000).
- Basic fetch: pc=0x100, ack with rdata=0x2408_0005 after 3 wait cycles, stall_d=0 → instr_f=0x2408_0005 and instr_valid_f=1 for one cycle. pc_en=1 in that HOLD cycle, next req addr=0x104.
- Decode stall: stall_d=1 for 4 cycles during HOLD → instr_f stable, pc_en=0, imem_req=0. Release → pc_en=1 exactly one cycle.
- Flush during wait: req to 0x200 outstanding, flush_d=1 with pc→0x400 → DROP. Ack data discarded (instr_valid_f stays 0); next req addr=0x400.
- Flush with ack and flush in HOLD: flush_d and imem_ack in the same cycle → no capture, pc_en=1. Flush while stall_d=1 in HOLD → valid cleared, pc_en=1.
- With IFETCH_TIMEOUT_EN and TO_CYCLES=16: no ack for 16 cycles → imem_req drops, fetch_err=1 held until rst=0, fetch restarts from IDLE.
